// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the ARM-subset pipeline registers: control-word
// layout and the ID/EXE transfer bundle.
package arm_pipe_pkg;

  localparam int PIPE_DATA_W = 32;
  localparam int CTRL_W      = 9;

  // Bit positions inside the decoded control word.
  localparam int CTRL_WB_EN      = 8;
  localparam int CTRL_MEM_R      = 7;
  localparam int CTRL_MEM_W      = 6;
  localparam int CTRL_EXE_CMD_HI = 5;
  localparam int CTRL_EXE_CMD_LO = 2;
  localparam int CTRL_B          = 1;
  localparam int CTRL_S          = 0;

  // Everything that travels from ID to EXE apart from the valid bit.
  // Field order matches the flat packing used by id_exe_stage_reg.
  typedef struct packed {
    logic [PIPE_DATA_W-1:0] pc;
    logic [CTRL_W-1:0]      ctrl;
    logic [PIPE_DATA_W-1:0] val_rn;
    logic [PIPE_DATA_W-1:0] val_rm;
    logic                   imm;
    logic [11:0]            shift_operand;
    logic [23:0]            signed_imm_24;
    logic [3:0]             dest;
    logic [3:0]             src1;
    logic [3:0]             src2;
    logic                   carry;
  } id_exe_bundle;

endpackage

// File: rtl/pipe_reg_ctl.sv
// Generic pipeline register with clear/hold control.
// Priority: rst > flush > hold > load; the clear value is all zeros.
module pipe_reg_ctl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         hold,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear on reset or flush, otherwise capture unless held.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      q <= '0;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register for the ARM-subset 5-stage core.
// Optional build macro: PERF_CNT_EN adds the stall_cnt/bubble_cnt counters.
//
// Slot semantics: out_valid=1 means the slot carries a real instruction.
// A slot with out_valid=0 always has out_ctrl=0, so it cannot write the
// register file, touch memory, branch or update flags. There is no ready;
// the upstream hazard unit owns freeze and the EXE branch logic owns flush.
module id_exe_stage_reg
  import arm_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 9,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_val_rn,
  input  logic [DATA_W-1:0] in_val_rm,
  input  logic              in_imm,
  input  logic [11:0]       in_shift_operand,
  input  logic [23:0]       in_signed_imm_24,
  input  logic [3:0]        in_dest,
  input  logic [3:0]        in_src1,
  input  logic [3:0]        in_src2,
  input  logic              in_carry,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_pc,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_val_rn,
  output logic [DATA_W-1:0] out_val_rm,
  output logic              out_imm,
  output logic [11:0]       out_shift_operand,
  output logic [23:0]       out_signed_imm_24,
  output logic [3:0]        out_dest,
  output logic [3:0]        out_src1,
  output logic [3:0]        out_src2,
  output logic              out_carry
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  localparam int BUNDLE_W = 3 * DATA_W + CTRL_W + 50;

  logic [CTRL_W-1:0]   ctrl_gated;
  logic [BUNDLE_W-1:0] bundle_d;
  logic [BUNDLE_W-1:0] bundle_q;

  // An invalid ID slot must not carry any control bits into EXE.
  assign ctrl_gated = in_valid ? in_ctrl : '0;

  assign bundle_d = {in_pc, ctrl_gated, in_val_rn, in_val_rm, in_imm,
                     in_shift_operand, in_signed_imm_24, in_dest,
                     in_src1, in_src2, in_carry};

  pipe_reg_ctl #(
    .W(BUNDLE_W)
  ) u_bundle_reg (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .hold (freeze),
    .d    (bundle_d),
    .q    (bundle_q)
  );

  assign {out_pc, out_ctrl, out_val_rn, out_val_rm, out_imm,
          out_shift_operand, out_signed_imm_24, out_dest,
          out_src1, out_src2, out_carry} = bundle_q;

  // Valid bit follows the same rst > flush > freeze > load priority.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid <= 1'b0;
    end else if (!freeze) begin
      out_valid <= in_valid;
    end
  end

  // Counter width must be at least one bit.
  if (CNT_W < 1) begin : g_bad_cnt_w
  end

`ifdef PERF_CNT_EN
  logic stall_cycle;
  logic bubble_cycle;

  // A stall is a frozen cycle that is not overridden by a flush; every
  // other cycle loads or flushes, and it is a bubble if the slot ends invalid.
  assign stall_cycle  = freeze && !flush;
  assign bubble_cycle = !stall_cycle && (flush || !in_valid);

  // Saturating counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall_cycle && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (bubble_cycle && (bubble_cnt != {CNT_W{1'b1}})) begin
        bubble_cnt <= bubble_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/id_exe_stage_reg.md
Name: id_exe_stage_reg

Overview:
- Pipeline register between the decode stage and the execute stage of the ARM-subset 5-stage core.
- Captures the decoded control word, operand values, immediate fields, destination, PC and status carry.
- Presents these to EXE one cycle later.
- Supports stall (freeze/hold) and flush (bubble insertion on taken branch), and tracks a valid bit per slot.

Parameters:
- DATA_W, 32, width of register-file values and PC
- CTRL_W, 9, width of the decoded control word
- CNT_W, 16, width of the optional performance counters

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  synchronous, active-high reset
- freeze  input  1  hazard stall; hold current contents
- flush  input  1  taken branch in EXE; insert a bubble
- in_valid  input  1  ID slot holds a real instruction
- in_pc  input  DATA_W  PC+4 of the ID instruction
- in_ctrl  input  CTRL_W  control word: [8]WB_EN [7]MEM_R_EN [6]MEM_W_EN [5:2]EXE_CMD [1]B [0]S
- in_val_rn  input  DATA_W  Rn value
- in_val_rm  input  DATA_W  Rm value (or Rd for stores)
- in_imm  input  1  I bit
- in_shift_operand  input  12  instruction[11:0]
- in_signed_imm_24  input  24  branch offset
- in_dest  input  4  Rd
- in_src1  input  4  Rn index
- in_src2  input  4  second source index
- in_carry  input  1  status register C flag at decode
- out_valid, out_pc, out_ctrl, out_val_rn, out_val_rm, out_imm, out_shift_operand, out_signed_imm_24, out_dest, out_carry  output  same widths  registered copies
- out_src1, out_src2  output  4  registered source indices (only present with FWD_SRC_EN)
- stall_cnt, bubble_cnt  output  CNT_W  performance counters (only present with PERF_CNT_EN)

Behaviour:
- All updates occur on the rising edge of clk; the block has no combinational path from input to output.
- Reset (rst=1):
  - Every output is cleared to 0, including out_valid, out_ctrl and the counters.
  - Reset overrides flush and freeze.
  - Reset asserted mid-stall clears the slot, and the next non-frozen cycle loads normally.
- Priority: rst > flush > freeze > load.
- Flush:
  - out_valid=0 and out_ctrl=0, so WB_EN, MEM_R_EN, MEM_W_EN, B and S are all low and the slot has no architectural effect.
  - Datapath outputs are also cleared to 0 for deterministic waveforms.
  - Flush with freeze high still clears the slot; a branch squash beats a stall.
- Freeze (and no flush): all outputs hold their previous values; in_* are ignored.
- Load (otherwise):
  - All out_* take the corresponding in_* values.
  - out_valid=in_valid.
  - If in_valid=0, out_ctrl is forced to 0 regardless of in_ctrl.
- Latency: exactly 1 cycle from in_* to out_* when not frozen or flushed.
- Consecutive freezes hold indefinitely with no drift.
- Back-to-back flushes keep the slot a bubble.
- No arithmetic is performed on the data fields; widths pass through unchanged.

Optional Feature:
- Macro: PERF_CNT_EN.
- Defined:
  - stall_cnt increments on each non-reset cycle with freeze=1 and flush=0.
  - bubble_cnt increments on each non-reset cycle where the loaded or flushed slot ends with out_valid=0.
  - Both counters saturate at all-ones, with no wrap.
  - Both counters clear only on rst.
- Undefined: ports stall_cnt and bubble_cnt and their logic are absent.
- FWD_SRC_EN:
  - FWD_SRC_EN is part of the interface definition, not a second optional feature.
  - The out_src1/out_src2 ports are always compiled unless the team's build omits forwarding.
  - Treat FWD_SRC_EN as fixed-on for this block.

Decomposition:
- Shared package arm_pipe_pkg holds:
  - CTRL_W, and bit-index constants CTRL_WB_EN=8, CTRL_MEM_R=7, CTRL_MEM_W=6, CTRL_EXE_CMD_HI=5, CTRL_EXE_CMD_LO=2, CTRL_B=1, CTRL_S=0.
  - The id_exe_bundle typedef (struct of all in_/out_ fields).
- One sub-module is natural: pipe_reg_ctl, a parametric-width register with rst/flush/hold priority and a clear value of 0.
  - It is instantiated for the data bundle.
  - The valid/ctrl gating and the counters live in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles with all in_* non-zero → every output is 0 on the cycle after.
- Load: in_valid=1, in_ctrl=9'h104, in_val_rn=32'hDEADBEEF, in_dest=4'd3 → out_* match one edge later, with out_valid=1.
- Freeze: load value A, then hold freeze=1 for 3 cycles while presenting B → out_val_rn stays A for those cycles; B appears on the edge after freeze drops. With PERF_CNT_EN, stall_cnt=3.
- Flush with freeze: slot holds 9'h1FF; freeze=1 and flush=1 on the same edge → out_ctrl=0, out_valid=0. With PERF_CNT_EN, bubble_cnt increments by 1 and stall_cnt is unchanged.
- Invalid input: in_valid=0, in_ctrl=9'h1FF → out_ctrl=0, out_valid=0.
- Counter saturation (PERF_CNT_EN, CNT_W=4): freeze=1 for 20 cycles → stall_cnt=4'hF; it is cleared to 0 only by rst.
